// File: rtl/led_sequencer_ctrl.sv
// led_sequencer_ctrl: command-driven 8-LED rotator with its own
// prescaled step timebase, counted or infinite runs, and completion pulse.
module led_sequencer_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] led,
    output logic       busy,
    output logic       step,
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STOP = 2'd2;
    localparam logic [1:0] OP_RATE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    led_q, led_d;
    logic          dir_q, dir_d;
    logic [6:0]    rem_q, rem_d;
    logic [1:0]    rate_q, rate_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          step_q, step_d;
    logic          done_q, done_d;

    logic accept;
    logic base_tick;
    logic hold_step;

    assign cmd_ready = (state_q != S_DONE);
    assign accept    = cmd_valid & cmd_ready;
    assign base_tick = (state_q == S_RUN) && (presc_q == PMAX);
    // Any command except a rate change pre-empts a coinciding step.
    assign hold_step = accept && (cmd_op != OP_RATE);

    assign led  = led_q;
    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;

    // Next-state: timebase and step first, then an accepted command overrides.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        rate_d  = rate_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        step_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_RUN: begin
                presc_d = base_tick ? '0 : presc_q + 1'b1;
                if (base_tick) begin
                    if (tick_q == rate_q) begin
                        tick_d = '0;
                        if (!hold_step) begin
                            step_d = 1'b1;
                            led_d  = dir_q ? {led_q[6:0], led_q[7]}
                                           : {led_q[0], led_q[7:1]};
                            if (rem_q != 7'd0) begin
                                rem_d = rem_q - 7'd1;
                                if (rem_q == 7'd1) begin
                                    state_d = S_DONE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end else if (tick_q > rate_q) begin
                        // Rate was lowered below the count: resync silently.
                        tick_d = '0;
                    end else begin
                        tick_d = tick_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                presc_d = '0;
                tick_d  = '0;
            end
            default: begin
                presc_d = '0;
            end
        endcase

        if (accept) begin
            unique case (cmd_op)
                OP_LOAD: begin
                    led_d = cmd_data;
                    if (state_q == S_RUN) begin
                        presc_d = '0;
                        tick_d  = '0;
                    end
                end
                OP_RUN: begin
                    dir_d   = cmd_data[7];
                    rem_d   = cmd_data[6:0];
                    state_d = S_RUN;
                    presc_d = '0;
                    tick_d  = '0;
                end
                OP_STOP: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    tick_d  = '0;
                end
                OP_RATE: begin
                    rate_d = cmd_data[1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_d = (state_d == S_RUN);

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            led_q   <= 8'h01;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            rate_q  <= '0;
            presc_q <= '0;
            tick_q  <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            rate_q  <= rate_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/led_sequencer_ctrl.md
# led_sequencer_ctrl

Command-driven controller that owns the board's 8-LED rotating display. It accepts load, run, stop and rate commands over a valid/ready handshake and generates its own step timebase from the 100 MHz system clock. It rotates the LED register a programmed number of steps, or indefinitely, and signals completion. It sits between the front-panel or host command logic and the LED pins, and replaces free-running rotation with sequenced, configurable behaviour.

## Interface
- `TICK_DIV`, default 100000000: clock cycles per base tick (1 s at 100 MHz). Legal range is TICK_DIV ≥ 2.
- `clock` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command (combinational, = state≠DONE).
- `cmd_op` in 2: 0 LOAD, 1 RUN, 2 STOP, 3 SET_RATE.
- `cmd_data` in 8: command payload.
- `led` out 8: LED pattern, registered.
- `busy` out 1: state==RUN, registered.
- `step` out 1: one-cycle pulse, asserted in the cycle after each LED update.
- `done` out 1: one-cycle pulse when a counted run completes.

## Operation
- States:
  - IDLE: prescaler held at 0.
  - RUN: prescaler counting.
  - DONE: one cycle long, then always IDLE.
- A command is accepted on an edge where cmd_valid & cmd_ready. Its effect is visible the following cycle.
- LOAD: led←cmd_data. State is unchanged. In RUN, the prescaler and tick counter clear to 0 and the remaining count is kept.
- RUN:
  - dir←cmd_data[7]; remaining←cmd_data[6:0].
  - remaining = 0 means infinite.
  - state→RUN; prescaler and tick counter clear to 0.
  - Accepted in RUN, it restarts with the new parameters.
- STOP: state→IDLE. led holds its value. Prescaler and tick counter clear. No done pulse.
- SET_RATE: rate←cmd_data[1:0]. Legal in any state. Prescaler is not cleared.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and wraps. Base tick = (prescaler==TICK_DIV-1) in RUN.
  - A 2-bit tick counter counts base ticks. A step occurs on a tick when tick_cnt==rate, then tick_cnt←0.
  - Step period is therefore TICK_DIV·(rate+1) cycles.
- Step action:
  - dir=0 (right): led←{led[0],led[7:1]}.
  - dir=1 (left): led←{led[6:0],led[7]}.
  - Counted run: remaining decrements (7-bit, no underflow). The step that takes remaining 1→0 also moves the state to DONE.
- Infinite run: the step count is never decremented and done never fires.

## Timing
- Reset values (asserted asynchronously, held while reset=0):
  - led=8'h01, state=IDLE, busy=0, step=0, done=0.
  - rate=0, dir=0, remaining=0, prescaler=0, tick_cnt=0.
- Reset mid-run aborts immediately with no done pulse. Operation resumes only after a new RUN.
- Latency from RUN accepted at edge E0:
  - First LED update at edge E0+TICK_DIV·(rate+1).
  - Each subsequent update every TICK_DIV·(rate+1) edges.
- step and done are registered and asserted on the update edge, so they are high for the cycle following it.
- For a counted run of N, done coincides with the Nth step. DONE occupies that same cycle, with cmd_ready=0 and busy=0.
- Simultaneous events:
  - A command accepted on a step edge wins. The step is suppressed (no led shift, no step pulse, no decrement) for LOAD, RUN and STOP.
  - SET_RATE on a step edge: the step executes under the old rate, and the new rate applies from the next tick.
  - SET_RATE with new rate < current tick_cnt: tick_cnt clears at the next tick without stepping.
- cmd_ready is low only in DONE. Commands held valid during DONE are accepted the next cycle, from IDLE.

## Test plan
- Reset, then release. Requirements:
  - led=0x01, busy=0, cmd_ready=1.
  - With no commands for 3·TICK_DIV cycles, led does not change.
- TICK_DIV=4: LOAD 0x81, then RUN 0x03 (right, 3 steps), rate 0. Requirements:
  - led goes 0xC0, 0x60, 0x30 at edges E0+4, +8, +12.
  - done=1 and step=1 in the same cycle, followed by IDLE.
- TICK_DIV=4: SET_RATE 2, then RUN 0x80 (left, infinite) from led=0x01. Requirements:
  - led goes 0x02, 0x04, … every 12 cycles.
  - 0x80 wraps to 0x01.
  - done never asserts.
- RUN counted 5 steps; STOP after the 2nd step. Requirements:
  - led frozen; busy=0 next cycle.
  - No done pulse.
  - A new RUN restarts timing from 0.
- LOAD issued on the exact step edge. Requirements:
  - led equals the LOAD data, not the shifted value.
  - No step pulse; remaining unchanged.
  - Next step occurs TICK_DIV·(rate+1) edges later.
- Assert reset mid-run, asynchronously between edges. Requirements:
  - led=0x01 and busy=0 immediately.
  - No done pulse.
  - After release, commands are accepted normally.
